// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives combinational imem address, fills IF/ID one edge after PC=A.
// Stall holds PC and IF/ID; a redirect overrides stall and costs exactly one bubble.
module fetch_unit #(
    parameter int unsigned             ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0,
    parameter int unsigned             CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] instraddr,
    input  logic [31:0]       instrcode,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_if_id_instr;
    logic [ADDR_W-1:0]   r_if_id_pc;
    logic                r_if_id_valid;
    logic                r_misalign;
    logic [CNT_W-1:0]    r_count;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [31:0]         w_instr_nxt;
    logic [ADDR_W-1:0]   w_if_id_pc_nxt;
    logic                w_valid_nxt;
    logic                w_misalign_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_id_instr <= w_instr_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_valid <= w_valid_nxt;
            r_misalign    <= w_misalign_nxt;
            r_count       <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_if_id_instr;
        w_if_id_pc_nxt = r_if_id_pc;
        w_valid_nxt    = r_if_id_valid;
        w_misalign_nxt = r_misalign;
        w_load         = 1'b0;
        unique case (r_state)
            // One edge of settled address before the first real fetch; redirects are dropped here.
            BOOT: w_state_nxt = RUN;
            RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt    = {redirect_target[ADDR_W-1:2], 2'b00};
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP;
                    if (redirect_target[1:0] != 2'b00) begin
                        w_misalign_nxt = 1'b1;
                    end
                end else if (!stall) begin
                    w_load         = 1'b1;
                    w_instr_nxt    = instrcode;
                    w_if_id_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_pc_nxt       = r_pc + ADDR_W'(4);
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_load && (r_count != {CNT_W{1'b1}})) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    assign instraddr    = r_pc;
    assign if_id_instr  = r_if_id_instr;
    assign if_id_pc     = r_if_id_pc;
    assign if_id_valid  = r_if_id_valid;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps push expected IF/ID state, a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [7:0]  instraddr;
    logic [31:0] instrcode;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic        misalign_err;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [7:0]  pc;
        logic [7:0]  addr;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'd0), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instraddr       (instraddr),
        .instrcode       (instrcode),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    assign instrcode = mem[instraddr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_instr"}, if_id_instr, 32'h0000_0013);
        chk({tag, "_pc"}, 32'(if_id_pc), 32'd0);
        chk({tag, "_addr"}, 32'(instraddr), 32'd0);
        chk({tag, "_mis"}, 32'(misalign_err), 32'd0);
        chk({tag, "_cnt"}, 32'(fetch_count), 32'd0);
    endtask

    // Applies inputs for the coming edge and records what IF/ID must hold after it.
    task automatic step(input logic s, input logic r, input logic [7:0] t,
                        input logic v, input logic [31:0] ins, input logic [7:0] pc,
                        input logic [7:0] addr, input logic mis, input logic [15:0] cnt);
        exp_t e;
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        e.v = v; e.ins = ins; e.pc = pc; e.addr = addr; e.mis = mis; e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("valid", 32'(if_id_valid), 32'(e.v));
            chk("instr", if_id_instr, e.ins);
            chk("if_id_pc", 32'(if_id_pc), 32'(e.pc));
            chk("instraddr", 32'(instraddr), 32'(e.addr));
            chk("misalign", 32'(misalign_err), 32'(e.mis));
            chk("count", 32'(fetch_count), 32'(e.cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0020_0613;
    localparam logic [31:0] I1  = 32'h0640_0793;
    localparam logic [31:0] I2  = 32'h0010_0513;
    localparam logic [31:0] I7  = 32'h00E6_C663;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i * 4);
        mem[0] = I0;
        mem[1] = I1;
        mem[2] = I2;
        mem[7] = I7;

        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        //   stall redir target  vld  instr         pc     addr    mis   cnt
        step(1'b0, 1'b0, 8'd0,   1'b0, NOP,          8'd0,  8'd0,   1'b0, 16'd0);
        step(1'b0, 1'b0, 8'd0,   1'b1, I0,           8'd0,  8'd4,   1'b0, 16'd1);
        step(1'b0, 1'b0, 8'd0,   1'b1, I1,           8'd4,  8'd8,   1'b0, 16'd2);
        step(1'b0, 1'b0, 8'd0,   1'b1, I2,           8'd8,  8'd12,  1'b0, 16'd3);
        step(1'b0, 1'b1, 8'd0,   1'b0, NOP,          8'd8,  8'd0,   1'b0, 16'd3);
        step(1'b0, 1'b0, 8'd0,   1'b1, I0,           8'd0,  8'd4,   1'b0, 16'd4);
        step(1'b0, 1'b0, 8'd0,   1'b1, I1,           8'd4,  8'd8,   1'b0, 16'd5);
        step(1'b1, 1'b0, 8'd0,   1'b1, I1,           8'd4,  8'd8,   1'b0, 16'd5);
        step(1'b1, 1'b0, 8'd0,   1'b1, I1,           8'd4,  8'd8,   1'b0, 16'd5);
        step(1'b0, 1'b0, 8'd0,   1'b1, I2,           8'd8,  8'd12,  1'b0, 16'd6);
        step(1'b1, 1'b1, 8'd28,  1'b0, NOP,          8'd8,  8'd28,  1'b0, 16'd6);
        step(1'b0, 1'b0, 8'd0,   1'b1, I7,           8'd28, 8'd32,  1'b0, 16'd7);
        step(1'b0, 1'b1, 8'd30,  1'b0, NOP,          8'd28, 8'd28,  1'b1, 16'd7);
        step(1'b0, 1'b0, 8'd0,   1'b1, I7,           8'd28, 8'd32,  1'b1, 16'd8);
        step(1'b0, 1'b0, 8'd0,   1'b1, 32'hA5000020, 8'd32, 8'd36,  1'b1, 16'd9);
        step(1'b0, 1'b1, 8'd252, 1'b0, NOP,          8'd32, 8'd252, 1'b1, 16'd9);
        step(1'b0, 1'b0, 8'd0,   1'b1, 32'hA50000FC, 8'd252,8'd0,   1'b1, 16'd10);
        step(1'b0, 1'b0, 8'd0,   1'b1, I0,           8'd0,  8'd4,   1'b1, 16'd11);

        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        step(1'b0, 1'b1, 8'd30,  1'b0, NOP,          8'd0,  8'd0,   1'b0, 16'd0);
        step(1'b0, 1'b0, 8'd0,   1'b1, I0,           8'd0,  8'd4,   1'b0, 16'd1);
        step(1'b0, 1'b0, 8'd0,   1'b1, I1,           8'd4,  8'd8,   1'b0, 16'd2);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
